// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit accumulation, dispense handshake
// with timeout, and change payout as a train of single-unit pulses.
module vend_controller #(
  parameter int PRICE        = 3,
  parameter int MAX_CREDIT   = 6,
  parameter int CREDIT_W     = 4,
  parameter int DISP_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                vend_done,
  output logic                vend_err,
  output logic [1:0]          o_state
);

  localparam int TMO_W = (DISP_TIMEOUT > 2) ? $clog2(DISP_TIMEOUT) : 1;
  localparam logic [CREDIT_W:0]   L_MAX      = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] L_PRICE    = CREDIT_W'(PRICE);
  localparam logic [TMO_W-1:0]    L_TMO_LAST = TMO_W'(DISP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_phase;
  logic                r_disp_req;
  logic                r_change_pulse;
  logic                r_coin_reject;
  logic                r_busy;
  logic                r_vend_done;
  logic                r_vend_err;

  logic [CREDIT_W:0]   w_coin_val;
  logic [CREDIT_W:0]   w_coin_sum;
  logic                w_coin_fits;
  logic                w_coin_any;

  always_comb begin
    w_coin_val = '0;
    case (coin)
      2'b01:   w_coin_val = {{(CREDIT_W-1){1'b0}}, 2'b01};
      2'b10:   w_coin_val = {{(CREDIT_W-1){1'b0}}, 2'b10};
      default: w_coin_val = '0;
    endcase
    w_coin_sum  = {1'b0, r_credit} + w_coin_val;
    w_coin_fits = (w_coin_sum <= L_MAX);
    w_coin_any  = (coin != 2'b00);
  end

  // Handshake: disp_req is raised on entry to DISPENSE and held until disp_ack
  // is sampled high or the timeout counter expires; ack wins a same-cycle tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_tmo          <= '0;
      r_phase        <= 1'b0;
      r_disp_req     <= 1'b0;
      r_change_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_busy         <= 1'b0;
      r_vend_done    <= 1'b0;
      r_vend_err     <= 1'b0;
    end else begin
      r_change_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_vend_done    <= 1'b0;
      r_vend_err     <= 1'b0;
      case (r_state)
        S_IDLE, S_CREDIT: begin
          if (cancel && (r_credit != '0)) begin
            r_state       <= S_CHANGE;
            r_busy        <= 1'b1;
            r_phase       <= 1'b0;
            r_coin_reject <= w_coin_any;
          end else if (sel && (r_credit >= L_PRICE)) begin
            r_credit      <= r_credit - L_PRICE;
            r_state       <= S_DISPENSE;
            r_disp_req    <= 1'b1;
            r_busy        <= 1'b1;
            r_tmo         <= '0;
            r_coin_reject <= w_coin_any;
          end else if (coin == 2'b11) begin
            r_coin_reject <= 1'b1;
          end else if (w_coin_any) begin
            if (w_coin_fits) begin
              r_credit <= w_coin_sum[CREDIT_W-1:0];
              r_state  <= S_CREDIT;
            end else begin
              r_coin_reject <= 1'b1;
            end
          end
        end
        S_DISPENSE: begin
          r_coin_reject <= w_coin_any;
          if (disp_ack) begin
            r_vend_done <= 1'b1;
            r_disp_req  <= 1'b0;
            if (r_credit != '0) begin
              r_state <= S_CHANGE;
              r_phase <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (r_tmo == L_TMO_LAST) begin
            r_vend_err <= 1'b1;
            r_disp_req <= 1'b0;
            r_credit   <= r_credit + L_PRICE;
            r_state    <= S_CHANGE;
            r_phase    <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_CHANGE: begin
          r_coin_reject <= w_coin_any;
          // phase 0 emits a pulse, phase 1 is the gap that may exit to IDLE
          if (!r_phase) begin
            if (r_credit != '0) begin
              r_change_pulse <= 1'b1;
              r_credit       <= r_credit - 1'b1;
              r_phase        <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_phase <= 1'b0;
            if (r_credit == '0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign disp_req     = r_disp_req;
  assign change_pulse = r_change_pulse;
  assign coin_reject  = r_coin_reject;
  assign credit       = r_credit;
  assign busy         = r_busy;
  assign vend_done    = r_vend_done;
  assign vend_err     = r_vend_err;
  assign o_state      = r_state;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: scenario tasks with a coin
// scoreboard queue of expected {coin_reject, credit} results.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       sel;
  logic       cancel;
  logic       disp_ack;
  logic       disp_req;
  logic       change_pulse;
  logic       coin_reject;
  logic [3:0] credit;
  logic       busy;
  logic       vend_done;
  logic       vend_err;
  logic [1:0] o_state;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  vend_controller #(.PRICE(3), .MAX_CREDIT(6), .CREDIT_W(4), .DISP_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .cancel(cancel),
    .disp_ack(disp_ack), .disp_req(disp_req), .change_pulse(change_pulse),
    .coin_reject(coin_reject), .credit(credit), .busy(busy),
    .vend_done(vend_done), .vend_err(vend_err), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_coin(input logic [1:0] c, input logic [4:0] exp);
    exp_q.push_back(exp);
    coin = c;
    cycle();
    coin = 2'b00;
  endtask

  // Watches CHANGE from its entry cycle (index 0) until busy falls.
  task automatic watch_change(input int first_at, output int n_pulse,
                              output int n_cyc, output bit spacing_ok);
    int prev;
    n_pulse    = 0;
    n_cyc      = -1;
    spacing_ok = 1'b1;
    prev       = 0;
    for (int i = 1; i < 60; i++) begin
      cycle();
      if (change_pulse) begin
        if (n_pulse == 0 ? (i != first_at) : (i - prev != 2)) spacing_ok = 1'b0;
        prev = i;
        n_pulse++;
      end
      if (!busy) begin
        n_cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_vec++;
    if ({disp_req, change_pulse, coin_reject, credit, busy, vend_done, vend_err, o_state} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 000",
               {disp_req, change_pulse, coin_reject, credit, busy, vend_done, vend_err, o_state});
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    cycle();
    n_vec++;
    if ({o_state, credit, busy} !== 7'h00) begin
      n_err++;
      $display("FAIL reset_idle: got %h expected 00", {o_state, credit, busy});
    end
  endtask

  task automatic test_vend_change();
    logic [1:0] cs[2] = '{2'b10, 2'b10};
    logic [3:0] ec[2] = '{4'd2, 4'd4};
    logic [4:0] exp;
    int np, nc;
    bit sp;
    for (int i = 0; i < 2; i++) begin
      drive_coin(cs[i], {1'b0, ec[i]});
      exp = exp_q.pop_front();
      n_vec++;
      if ({coin_reject, credit} !== exp) begin
        n_err++;
        $display("FAIL vend_coin%0d: got %h expected %h", i, {coin_reject, credit}, exp);
      end
    end
    sel = 1'b1;
    cycle();
    sel = 1'b0;
    n_vec++;
    if ({disp_req, busy, credit} !== {1'b1, 1'b1, 4'd1}) begin
      n_err++;
      $display("FAIL vend_sel: got %h expected %h", {disp_req, busy, credit}, {1'b1, 1'b1, 4'd1});
    end
    cycle();
    cycle();
    disp_ack = 1'b1;
    cycle();
    disp_ack = 1'b0;
    n_vec++;
    if ({vend_done, disp_req, busy, o_state} !== {1'b1, 1'b0, 1'b1, 2'd3}) begin
      n_err++;
      $display("FAIL vend_ack: got %h expected %h", {vend_done, disp_req, busy, o_state}, {1'b1, 1'b0, 1'b1, 2'd3});
    end
    watch_change(1, np, nc, sp);
    n_vec++;
    if ({np[3:0], nc[3:0], sp} !== {4'd1, 4'd2, 1'b1}) begin
      n_err++;
      $display("FAIL vend_change: got pulses=%0d cycles=%0d spacing=%0d expected 1 2 1", np, nc, sp);
    end
    n_vec++;
    if ({o_state, credit} !== 6'h00) begin
      n_err++;
      $display("FAIL vend_final: got %h expected 00", {o_state, credit});
    end
  endtask

  task automatic test_overflow();
    logic [1:0] cs[8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b01};
    logic [4:0] ex[8] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h15, 5'h15, 5'h06};
    logic [4:0] exp;
    int np, nc;
    bit sp;
    for (int i = 0; i < 8; i++) begin
      drive_coin(cs[i], ex[i]);
      exp = exp_q.pop_front();
      n_vec++;
      if ({coin_reject, credit} !== exp) begin
        n_err++;
        $display("FAIL overflow_coin%0d: got %h expected %h", i, {coin_reject, credit}, exp);
      end
    end
    cancel = 1'b1;
    cycle();
    cancel = 1'b0;
    watch_change(1, np, nc, sp);
    n_vec++;
    if ({np[3:0], nc[4:0], sp} !== {4'd6, 5'd12, 1'b1}) begin
      n_err++;
      $display("FAIL overflow_refund: got pulses=%0d cycles=%0d spacing=%0d expected 6 12 1", np, nc, sp);
    end
  endtask

  task automatic test_timeout();
    logic [4:0] exp;
    int hi, np, nc;
    bit sp;
    for (int i = 0; i < 3; i++) begin
      drive_coin(2'b01, {1'b0, 4'(i + 1)});
      exp = exp_q.pop_front();
      n_vec++;
      if ({coin_reject, credit} !== exp) begin
        n_err++;
        $display("FAIL timeout_coin%0d: got %h expected %h", i, {coin_reject, credit}, exp);
      end
    end
    sel = 1'b1;
    cycle();
    sel = 1'b0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!disp_req) break;
      hi++;
      cycle();
    end
    n_vec++;
    if (hi != 16) begin
      n_err++;
      $display("FAIL timeout_req_len: got %0d expected 16", hi);
    end
    n_vec++;
    if ({vend_err, credit, o_state} !== {1'b1, 4'd3, 2'd3}) begin
      n_err++;
      $display("FAIL timeout_err: got %h expected %h", {vend_err, credit, o_state}, {1'b1, 4'd3, 2'd3});
    end
    watch_change(1, np, nc, sp);
    n_vec++;
    if ({np[3:0], nc[3:0], sp, o_state} !== {4'd3, 4'd6, 1'b1, 2'd0}) begin
      n_err++;
      $display("FAIL timeout_change: got pulses=%0d cycles=%0d spacing=%0d state=%0d expected 3 6 1 0",
               np, nc, sp, o_state);
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] exp;
    int np, nc;
    bit sp;
    drive_coin(2'b01, 5'h01);
    drive_coin(2'b10, 5'h03);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_vec++;
      if (i == 1 && {coin_reject, credit} !== exp) begin
        n_err++;
        $display("FAIL simul_setup: got %h expected %h", {coin_reject, credit}, exp);
      end
    end
    sel = 1'b1;
    coin = 2'b01;
    @(posedge clk);
    #1;
    sel = 1'b0;
    coin = 2'b00;
    n_vec++;
    if ({disp_req, coin_reject, credit} !== {1'b1, 1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL simul_sel_coin: got %h expected %h", {disp_req, coin_reject, credit}, {1'b1, 1'b1, 4'd0});
    end
    disp_ack = 1'b1;
    cycle();
    disp_ack = 1'b0;
    n_vec++;
    if ({vend_done, busy, o_state} !== {1'b1, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL simul_ack_idle: got %h expected %h", {vend_done, busy, o_state}, {1'b1, 1'b0, 2'd0});
    end
    drive_coin(2'b10, 5'h02);
    exp = exp_q.pop_front();
    n_vec++;
    if ({coin_reject, credit} !== exp) begin
      n_err++;
      $display("FAIL simul_coin: got %h expected %h", {coin_reject, credit}, exp);
    end
    exp_q.push_back(5'h03);
    sel = 1'b1;
    coin = 2'b01;
    cycle();
    sel = 1'b0;
    coin = 2'b00;
    exp = exp_q.pop_front();
    n_vec++;
    if ({disp_req, o_state, coin_reject, credit} !== {1'b0, 2'd1, exp}) begin
      n_err++;
      $display("FAIL simul_low_credit: got %h expected %h", {disp_req, o_state, coin_reject, credit}, {1'b0, 2'd1, exp});
    end
    cancel = 1'b1;
    cycle();
    cancel = 1'b0;
    watch_change(1, np, nc, sp);
    n_vec++;
    if ({np[3:0], nc[3:0], sp} !== {4'd3, 4'd6, 1'b1}) begin
      n_err++;
      $display("FAIL simul_refund: got pulses=%0d cycles=%0d spacing=%0d expected 3 6 1", np, nc, sp);
    end
  endtask

  task automatic test_cancel();
    logic [4:0] exp;
    int np, nc;
    bit sp;
    drive_coin(2'b10, 5'h02);
    exp = exp_q.pop_front();
    n_vec++;
    if ({coin_reject, credit} !== exp) begin
      n_err++;
      $display("FAIL cancel_coin: got %h expected %h", {coin_reject, credit}, exp);
    end
    cancel = 1'b1;
    cycle();
    cancel = 1'b0;
    n_vec++;
    if ({busy, o_state, credit} !== {1'b1, 2'd3, 4'd2}) begin
      n_err++;
      $display("FAIL cancel_enter: got %h expected %h", {busy, o_state, credit}, {1'b1, 2'd3, 4'd2});
    end
    coin = 2'b01;
    cycle();
    coin = 2'b00;
    n_vec++;
    if ({coin_reject, change_pulse, credit} !== {1'b1, 1'b1, 4'd1}) begin
      n_err++;
      $display("FAIL cancel_busy_coin: got %h expected %h", {coin_reject, change_pulse, credit}, {1'b1, 1'b1, 4'd1});
    end
    watch_change(2, np, nc, sp);
    n_vec++;
    if ({np[3:0], nc[3:0], sp} !== {4'd1, 4'd3, 1'b1}) begin
      n_err++;
      $display("FAIL cancel_drain: got pulses=%0d cycles=%0d spacing=%0d expected 1 3 1", np, nc, sp);
    end
    np = 0;
    cancel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (change_pulse || busy) np++;
    end
    cancel = 1'b0;
    n_vec++;
    if ({np[3:0], o_state, credit} !== 10'h000) begin
      n_err++;
      $display("FAIL cancel_idle_ignored: got active=%0d state=%0d credit=%0d expected 0 0 0", np, o_state, credit);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp;
    drive_coin(2'b10, 5'h02);
    drive_coin(2'b01, 5'h03);
    exp = exp_q.pop_front();
    exp = exp_q.pop_front();
    n_vec++;
    if ({coin_reject, credit} !== exp) begin
      n_err++;
      $display("FAIL rstmid_setup: got %h expected %h", {coin_reject, credit}, exp);
    end
    sel = 1'b1;
    cycle();
    sel = 1'b0;
    cycle();
    n_vec++;
    if ({disp_req, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL rstmid_dispense: got %b expected 11", {disp_req, busy});
    end
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({disp_req, credit, busy, o_state} !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_async: got %h expected 00", {disp_req, credit, busy, o_state});
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    disp_ack = 1'b1;
    cycle();
    cycle();
    disp_ack = 1'b0;
    n_vec++;
    if ({disp_req, vend_done, busy, o_state, credit} !== 9'h000) begin
      n_err++;
      $display("FAIL rstmid_ack_ignored: got %h expected 000", {disp_req, vend_done, busy, o_state, credit});
    end
  endtask

  initial begin
    coin     = 2'b00;
    sel      = 1'b0;
    cancel   = 1'b0;
    disp_ack = 1'b0;
    test_reset();
    test_vend_change();
    test_overflow();
    test_timeout();
    test_simultaneous();
    test_cancel();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction sequencer for the coin-operated vending datapath. Accumulates coin credit in 5-rs units, accepts a buy request when credit covers the price, and runs a req/ack handshake with the product dispenser, with a timeout. It then pays out the remaining credit as a train of single 5-rs change pulses. It sits between the coin acceptor / front-panel buttons and the dispenser and change-hopper actuators.

## Interface
- PRICE, default 3: item price in 5-rs units (3 = 15 rs); must satisfy 1 ≤ PRICE ≤ MAX_CREDIT.
- MAX_CREDIT, default 6: maximum credit held, in 5-rs units.
- CREDIT_W, default 4: credit register width; must hold MAX_CREDIT.
- DISP_TIMEOUT, default 16: cycles to wait for disp_ack before aborting; ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin  in  [1:0]  coin event this cycle. 00 = none, 01 = 5 rs, 10 = 10 rs, 11 = invalid.
- sel  in  1  buy request, level-sampled each cycle.
- cancel  in  1  refund request, level-sampled each cycle.
- disp_ack  in  1  dispenser completed the item.
- disp_req  out  1  dispense request; held until ack or timeout.
- change_pulse  out  1  one-cycle pulse = eject one 5-rs coin.
- coin_reject  out  1  one-cycle pulse = return the coin presented last cycle.
- credit  out  [CREDIT_W-1:0]  current credit, in 5-rs units.
- busy  out  1  high in DISPENSE or CHANGE.
- vend_done  out  1  one-cycle pulse on successful dispense.
- vend_err  out  1  one-cycle pulse on dispense timeout.

## Operation
- States: IDLE (credit = 0), CREDIT (credit > 0), DISPENSE, CHANGE.
- Coin value: 01 → +1, 10 → +2.
- **IDLE/CREDIT coin handling**
  - A coin is accepted when credit + value ≤ MAX_CREDIT.
  - Otherwise credit is unchanged and coin_reject is pulsed.
  - Code 11 is always rejected.
  - A credit-changing coin in IDLE moves the FSM to CREDIT.
- **IDLE/CREDIT priority: cancel > sel > coin**
  - cancel with credit > 0: go to CHANGE.
  - cancel with credit = 0: ignored.
  - sel with credit ≥ PRICE: credit -= PRICE, go to DISPENSE.
  - sel with credit < PRICE: ignored; the coin that cycle is still processed normally.
  - When cancel or sel is accepted, a coin presented in the same cycle is rejected.
- **DISPENSE**
  - disp_req = 1; timeout counter starts at 0 on entry and increments each cycle.
  - disp_ack = 1: pulse vend_done, go to CHANGE if credit > 0, else IDLE.
  - Counter reaches DISP_TIMEOUT−1 without ack: pulse vend_err, credit += PRICE (full refund), go to CHANGE.
  - If ack and timeout occur in the same cycle, ack wins.
  - cancel and sel are ignored.
- **CHANGE**
  - Alternates pulse and gap cycles: change_pulse = 1 with credit -= 1, then one cycle low.
  - Goes to IDLE on the gap cycle after credit reaches 0.
  - sel and cancel are ignored.
- All coins presented in DISPENSE or CHANGE are rejected.
- disp_ack outside DISPENSE is ignored.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, credit 0, timeout counter 0. Reset assertion at any time applies these immediately (asynchronous); credit in flight is discarded and disp_req drops at once.
- coin_reject and credit update are visible the cycle after the coin is sampled.
- disp_req rises the cycle after sel is accepted; credit shows the post-deduction value in that same cycle.
- disp_req falls, and vend_done pulses, the cycle after disp_ack is sampled.
- On timeout: disp_req is high for exactly DISP_TIMEOUT cycles; vend_err pulses and disp_req falls together in the next cycle.
- First change_pulse occurs the cycle after entering CHANGE. N units of change take 2N cycles in CHANGE; then busy drops.
- busy = 1 exactly while the state is DISPENSE or CHANGE.
- Credit never exceeds MAX_CREDIT and never underflows.

## Test plan
- **Vend with change:** PRICE=3, reset released; coin 10, coin 10 → credit 2 then 4; sel → disp_req=1, credit=1; disp_ack after 3 cycles → vend_done pulse, one change_pulse, busy falls, credit=0, IDLE.
- **Overflow and invalid coins:** coin 01 ×5 → credit=5; coin 10 → coin_reject, credit stays 5; coin 11 → coin_reject; coin 01 → credit=6.
- **Timeout:** credit 3, sel, no disp_ack → disp_req high 16 cycles, vend_err pulse, credit=3, three change_pulses spaced 2 cycles apart, IDLE.
- **Simultaneous inputs:** credit=3; sel and coin 01 in the same cycle → DISPENSE, coin_reject, credit=0. Credit=2; sel and coin 01 → coin accepted, credit=3, no dispense.
- **Cancel, busy rejection, ignored cancel:** credit 2, cancel → 2 change_pulses. Coin during CHANGE → coin_reject. cancel in IDLE → no change_pulse.
- **Reset mid-operation:** assert rst low mid-DISPENSE → disp_req, credit and busy are 0 immediately. After release → IDLE; disp_ack is ignored.
